// File: rtl/ooo_pkg.sv
// Shared decode definitions: opcode groups (inst[6:2]), functional-unit
// select encoding and the decoded-entry record carried by the decode queue.
package ooo_pkg;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_FLOAD  = 5'b00001;
   localparam logic [4:0] OP_I_TYPE = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_S_TYPE = 5'b01000;
   localparam logic [4:0] OP_FSTORE = 5'b01001;
   localparam logic [4:0] OP_R_TYPE = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_F_TYPE = 5'b10100;
   localparam logic [4:0] OP_B_TYPE = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_CSR    = 5'b11100;

   // R_TYPE uses {2'b0, f7[0]}, so FU_ALU/FU_MUL share that slot
   localparam logic [2:0] FU_ALU   = 3'd0;
   localparam logic [2:0] FU_MUL   = 3'd1;
   localparam logic [2:0] FU_FPU   = 3'd3;
   localparam logic [2:0] FU_LOAD  = 3'd6;
   localparam logic [2:0] FU_STORE = 3'd7;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] imm;
      logic [4:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [5:0]  A_rs1;
      logic [5:0]  A_rs2;
      logic [5:0]  A_rd;
      logic        allocate_rd;
      logic [2:0]  fu_sel;
      logic        jump;
   } dec_t;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/dc_decoder.sv
// Combinational single-lane decoder: raw fetch lane -> dec_t record.
module dc_decoder
   import ooo_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_inst,
   input  logic        i_jump,
   output dec_t        o_dec
);

   logic [4:0] w_op;
   logic       w_fp_rs1;
   logic       w_fp_rs2;
   logic       w_fp_rd;

   assign w_op     = i_inst[6:2];
   assign w_fp_rs1 = (w_op == OP_F_TYPE);
   assign w_fp_rs2 = (w_op == OP_F_TYPE) || (w_op == OP_FSTORE);
   assign w_fp_rd  = (w_op == OP_F_TYPE) || (w_op == OP_FLOAD);

   // field extraction, immediate format selection and unit steering
   always_comb begin
      o_dec       = '0;
      o_dec.pc    = i_pc;
      o_dec.inst  = i_inst;
      o_dec.op    = w_op;
      o_dec.f3    = i_inst[14:12];
      o_dec.f7    = i_inst[31:25];
      o_dec.A_rs1 = {w_fp_rs1, i_inst[19:15]};
      o_dec.A_rs2 = {w_fp_rs2, i_inst[24:20]};
      o_dec.A_rd  = {w_fp_rd, i_inst[11:7]};
      o_dec.jump  = i_jump;

      case (w_op)
         OP_B_TYPE: o_dec.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                 i_inst[30:25], i_inst[11:8], 1'b0};
         OP_JAL:    o_dec.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                 i_inst[20], i_inst[30:21], 1'b0};
         OP_I_TYPE, OP_LOAD, OP_FLOAD, OP_JALR:
                    o_dec.imm = sext12(i_inst[31:20]);
         OP_S_TYPE, OP_FSTORE:
                    o_dec.imm = sext12({i_inst[31:25], i_inst[11:7]});
         OP_LUI, OP_AUIPC:
                    o_dec.imm = {i_inst[31:12], 12'b0};
         OP_CSR:    o_dec.imm = {20'b0, i_inst[31:20]};
         default:   o_dec.imm = '0;
      endcase

      case (w_op)
         OP_R_TYPE:            o_dec.fu_sel = {2'b0, i_inst[25]};
         OP_F_TYPE:            o_dec.fu_sel = FU_FPU;
         OP_LOAD, OP_FLOAD:    o_dec.fu_sel = FU_LOAD;
         OP_S_TYPE, OP_FSTORE: o_dec.fu_sel = FU_STORE;
         default:              o_dec.fu_sel = FU_ALU;
      endcase

      o_dec.allocate_rd = !((w_op == OP_S_TYPE) || (w_op == OP_FSTORE) ||
                            (w_op == OP_B_TYPE) || (o_dec.A_rd == 6'd0));
   end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: decodes up to WIDTH fetch lanes per cycle into a circular
// buffer of dec_t records, presents the oldest WIDTH entries to dispatch and
// optionally issues an early redirect for unpredicted JALs.
module decode_queue
   import ooo_pkg::*;
#(
   parameter int WIDTH     = 2,
   parameter int DEPTH     = 8,
   parameter bit EARLY_JAL = 1'b1
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             in_valid,
   input  logic [WIDTH-1:0][31:0]       in_pc,
   input  logic [WIDTH-1:0][31:0]       in_inst,
   input  logic [WIDTH-1:0]             in_jump,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             out_valid,
   output dec_t [WIDTH-1:0]             out_dec,
   input  logic [$clog2(WIDTH+1)-1:0]   deq_cnt,
   input  logic                         flush,
   output logic                         redirect_valid,
   output logic [31:0]                  redirect_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - WIDTH);

   dec_t          w_dec    [WIDTH];
   dec_t          w_wr_dec [WIDTH];
   dec_t          r_mem    [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_redirect_valid;
   logic [31:0]   r_redirect_pc;

   logic             w_enq_fire;
   logic [WIDTH-1:0] w_lane_wr;
   logic [CW-1:0]    w_enq_n;
   logic [CW-1:0]    w_enq_add;
   logic [CW-1:0]    w_deq_n;
   logic             w_jal_hit;
   logic [31:0]      w_jal_tgt;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      dc_decoder u_dec (
         .i_pc   (in_pc[g]),
         .i_inst (in_inst[g]),
         .i_jump (in_jump[g]),
         .o_dec  (w_dec[g])
      );
   end

   assign in_ready   = rst && (r_count <= READY_MAX) && !flush && !r_redirect_valid;
   assign w_enq_fire = in_ready && in_valid[0];
   assign w_enq_add  = w_enq_fire ? w_enq_n : '0;
   assign w_deq_n    = (CW'(deq_cnt) > r_count) ? r_count : CW'(deq_cnt);

   // select enqueuing lanes: contiguous from lane 0, truncated after the
   // first unpredicted JAL, which also supplies the redirect target
   always_comb begin
      logic l_stop;
      l_stop    = 1'b0;
      w_lane_wr = '0;
      w_enq_n   = '0;
      w_jal_hit = 1'b0;
      w_jal_tgt = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         w_wr_dec[i] = w_dec[i];
         // any written JAL is either already predicted or is the redirecting lane
         w_wr_dec[i].jump = w_dec[i].jump || (EARLY_JAL && (w_dec[i].op == OP_JAL));
         if (in_valid[i] && !l_stop) begin
            w_lane_wr[i] = 1'b1;
            w_enq_n      = w_enq_n + CW'(1);
            if (EARLY_JAL && (w_dec[i].op == OP_JAL) && !in_jump[i]) begin
               w_jal_hit = 1'b1;
               w_jal_tgt = w_dec[i].pc + w_dec[i].imm;
               l_stop    = 1'b1;
            end
         end else begin
            l_stop = 1'b1;
         end
      end
   end

   // pointer, occupancy and redirect state
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else if (flush) begin
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_redirect_valid <= 1'b0;
      end else begin
         r_tail           <= r_tail + PW'(w_enq_add);
         r_head           <= r_head + PW'(w_deq_n);
         r_count          <= r_count + w_enq_add - w_deq_n;
         r_redirect_valid <= w_enq_fire && w_jal_hit;
         if (w_enq_fire && w_jal_hit) begin
            r_redirect_pc <= w_jal_tgt;
         end
      end
   end

   // entry storage, written in lane order at the tail
   always_ff @(posedge clk) begin
      if (w_enq_fire) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w_lane_wr[i]) begin
               r_mem[r_tail + PW'(i)] <= w_wr_dec[i];
            end
         end
      end
   end

   // oldest-first view of the buffer for dispatch
   always_comb begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
         out_valid[i] = (r_count > CW'(i));
         out_dec[i]   = r_mem[r_head + PW'(i)];
      end
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (WIDTH=2, DEPTH=8, EARLY_JAL=1).
module tb_decode_queue;
   import ooo_pkg::*;

   localparam int WIDTH = 2;
   localparam int DEPTH = 8;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [WIDTH-1:0]       in_valid = '0;
   logic [WIDTH-1:0][31:0] in_pc    = '0;
   logic [WIDTH-1:0][31:0] in_inst  = '0;
   logic [WIDTH-1:0]       in_jump  = '0;
   logic                   in_ready;
   logic [WIDTH-1:0]       out_valid;
   dec_t [WIDTH-1:0]       out_dec;
   logic [1:0]             deq_cnt  = '0;
   logic                   flush    = 1'b0;
   logic                   redirect_valid;
   logic [31:0]            redirect_pc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EARLY_JAL(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
      .in_inst(in_inst), .in_jump(in_jump), .in_ready(in_ready),
      .out_valid(out_valid), .out_dec(out_dec), .deq_cnt(deq_cnt),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        jump;
      logic [31:0] imm;
      logic [2:0]  fu;
      logic        alloc;
      logic [5:0]  rd;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
   } vec_t;

   localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
   localparam logic [31:0] I_ADDM = 32'hFFF08113;  // addi x2,x1,-1
   localparam logic [31:0] I_JAL  = 32'h040000EF;  // jal x1,+0x40
   localparam logic [31:0] I_FLW  = 32'h0080A207;  // flw f4,8(x1)
   localparam logic [31:0] I_FSW  = 32'h0050A227;  // fsw f5,4(x1)

   vec_t vt [15];

   function automatic vec_t mk(input logic [31:0] pc, inst, input logic j,
                               input logic [31:0] imm, input logic [2:0] fu,
                               input logic al, input logic [5:0] rd, rs1, rs2);
      vec_t v;
      v.pc = pc; v.inst = inst; v.jump = j; v.imm = imm; v.fu = fu;
      v.alloc = al; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] inst,
                           input logic j);
      in_pc[l] = pc; in_inst[l] = inst; in_jump[l] = j;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vt[0]  = mk(32'h10, I_ADDI,       0, 32'h5,        3'd0, 1, 6'd1,  6'd0,  6'd5);
      vt[1]  = mk(32'h14, I_ADDM,       0, 32'hFFFFFFFF, 3'd0, 1, 6'd2,  6'd1,  6'd31);
      vt[2]  = mk(32'h18, 32'h00C12283, 0, 32'hC,        3'd6, 1, 6'd5,  6'd2,  6'd12);
      vt[3]  = mk(32'h1C, 32'hFE612E23, 0, 32'hFFFFFFFC, 3'd7, 0, 6'd28, 6'd2,  6'd6);
      vt[4]  = mk(32'h20, 32'h00208863, 0, 32'h10,       3'd0, 0, 6'd16, 6'd1,  6'd2);
      vt[5]  = mk(32'h24, 32'h002081B3, 0, 32'h0,        3'd0, 1, 6'd3,  6'd1,  6'd2);
      vt[6]  = mk(32'h28, 32'h022081B3, 0, 32'h0,        3'd1, 1, 6'd3,  6'd1,  6'd2);
      vt[7]  = mk(32'h2C, 32'h123453B7, 0, 32'h12345000, 3'd0, 1, 6'd7,  6'd8,  6'd3);
      vt[8]  = mk(32'h30, 32'h00001417, 0, 32'h1000,     3'd0, 1, 6'd8,  6'd0,  6'd0);
      vt[9]  = mk(32'h34, 32'h008280E7, 0, 32'h8,        3'd0, 1, 6'd1,  6'd5,  6'd8);
      vt[10] = mk(32'h38, 32'h003100D3, 0, 32'h0,        3'd3, 1, 6'h21, 6'h22, 6'h23);
      vt[11] = mk(32'h3C, I_FLW,        0, 32'h8,        3'd6, 1, 6'h24, 6'd1,  6'd8);
      vt[12] = mk(32'h40, I_FSW,        0, 32'h4,        3'd7, 0, 6'd4,  6'd1,  6'h25);
      vt[13] = mk(32'h44, 32'hFF9FF06F, 1, 32'hFFFFFFF8, 3'd0, 0, 6'd0,  6'd31, 6'd25);
      vt[14] = mk(32'h48, 32'h00000013, 0, 32'h0,        3'd0, 0, 6'd0,  6'd0,  6'd0);

      // reset state
      tick(); tick();
      chk("rst.out_valid", out_valid, 2'b00);
      chk("rst.redirect_valid", redirect_valid, 1'b0);
      chk("rst.redirect_pc", redirect_pc, 32'h0);
      chk("rst.in_ready", in_ready, 1'b0);
      rst = 1'b1;
      #1;
      chk("post_rst.in_ready", in_ready, 1'b1);

      // two ADDIs in one group
      set_lane(0, 32'h100, I_ADDI, 0);
      set_lane(1, 32'h104, I_ADDM, 0);
      in_valid = 2'b11;
      tick();
      in_valid = '0;
      chk("addi.out_valid", out_valid, 2'b11);
      chk("addi.pc0", out_dec[0].pc, 32'h100);
      chk("addi.imm0", out_dec[0].imm, 32'h5);
      chk("addi.pc1", out_dec[1].pc, 32'h104);
      chk("addi.imm1", out_dec[1].imm, 32'hFFFFFFFF);
      chk("addi.fu0", out_dec[0].fu_sel, 3'd0);
      chk("addi.fu1", out_dec[1].fu_sel, 3'd0);
      deq_cnt = 2'd2;
      tick();
      deq_cnt = '0;
      chk("addi.drained", out_valid, 2'b00);

      // decode table, one entry at a time through lane 0
      for (int r = 0; r < 15; r++) begin
         set_lane(0, vt[r].pc, vt[r].inst, vt[r].jump);
         in_valid = 2'b01;
         tick();
         in_valid = '0;
         chk($sformatf("row%0d.out_valid", r), out_valid, 2'b01);
         chk($sformatf("row%0d.pc", r), out_dec[0].pc, vt[r].pc);
         chk($sformatf("row%0d.imm", r), out_dec[0].imm, vt[r].imm);
         chk($sformatf("row%0d.fu_sel", r), out_dec[0].fu_sel, vt[r].fu);
         chk($sformatf("row%0d.alloc", r), out_dec[0].allocate_rd, vt[r].alloc);
         chk($sformatf("row%0d.A_rd", r), out_dec[0].A_rd, vt[r].rd);
         chk($sformatf("row%0d.A_rs1", r), out_dec[0].A_rs1, vt[r].rs1);
         chk($sformatf("row%0d.A_rs2", r), out_dec[0].A_rs2, vt[r].rs2);
         chk($sformatf("row%0d.jump", r), out_dec[0].jump, vt[r].jump);
         chk($sformatf("row%0d.redirect", r), redirect_valid, 1'b0);
         deq_cnt = 2'd1;
         tick();
         deq_cnt = '0;
      end

      // unpredicted JAL in lane 0 drops lane 1 and redirects once
      set_lane(0, 32'h200, I_JAL, 0);
      set_lane(1, 32'h204, I_ADDI, 0);
      in_valid = 2'b11;
      tick();
      set_lane(0, 32'h300, I_ADDI, 0);
      set_lane(1, 32'h304, I_ADDI, 0);
      chk("jal0.out_valid", out_valid, 2'b01);
      chk("jal0.pc", out_dec[0].pc, 32'h200);
      chk("jal0.jump", out_dec[0].jump, 1'b1);
      chk("jal0.redirect_valid", redirect_valid, 1'b1);
      chk("jal0.redirect_pc", redirect_pc, 32'h240);
      chk("jal0.in_ready", in_ready, 1'b0);
      tick();
      in_valid = '0;
      chk("jal0.pulse_end", redirect_valid, 1'b0);
      chk("jal0.no_enq", out_valid, 2'b01);
      deq_cnt = 2'd1;
      tick();
      deq_cnt = '0;

      // unpredicted JAL in lane 1: both lanes kept
      set_lane(0, 32'h400, I_ADDI, 0);
      set_lane(1, 32'h404, I_JAL, 0);
      in_valid = 2'b11;
      tick();
      in_valid = '0;
      chk("jal1.out_valid", out_valid, 2'b11);
      chk("jal1.jump0", out_dec[0].jump, 1'b0);
      chk("jal1.jump1", out_dec[1].jump, 1'b1);
      chk("jal1.redirect_valid", redirect_valid, 1'b1);
      chk("jal1.redirect_pc", redirect_pc, 32'h444);
      deq_cnt = 2'd2;
      tick();
      deq_cnt = '0;
      chk("jal1.pulse_end", redirect_valid, 1'b0);

      // JAL presented together with flush: no redirect, no entry
      set_lane(0, 32'h200, I_JAL, 0);
      in_valid = 2'b01;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = '0;
      chk("flushjal.redirect", redirect_valid, 1'b0);
      chk("flushjal.out_valid", out_valid, 2'b00);

      // flush at count 5 with concurrent enqueue and dequeue
      set_lane(0, 32'h500, I_ADDI, 0);
      set_lane(1, 32'h504, I_ADDI, 0);
      in_valid = 2'b11;
      tick();
      tick();
      in_valid = 2'b01;
      tick();
      chk("pre_flush.out_valid", out_valid, 2'b11);
      in_valid = 2'b11;
      deq_cnt = 2'd1;
      flush = 1'b1;
      #1;
      chk("flush.in_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0;
      in_valid = '0;
      deq_cnt = '0;
      chk("flush.out_valid", out_valid, 2'b00);
      set_lane(0, 32'h700, I_ADDI, 0);
      in_valid = 2'b01;
      tick();
      in_valid = '0;
      chk("post_flush.out_valid", out_valid, 2'b01);
      chk("post_flush.pc", out_dec[0].pc, 32'h700);
      deq_cnt = 2'd1;
      tick();
      deq_cnt = '0;

      // over-dequeue clamps; then FLW/FSW register-file tagging
      set_lane(0, 32'h800, I_ADDI, 0);
      in_valid = 2'b01;
      tick();
      in_valid = '0;
      deq_cnt = 2'd2;
      tick();
      deq_cnt = '0;
      chk("clamp.out_valid", out_valid, 2'b00);
      set_lane(0, 32'h900, I_FLW, 0);
      set_lane(1, 32'h904, I_FSW, 0);
      in_valid = 2'b11;
      tick();
      in_valid = '0;
      chk("clamp.refill", out_valid, 2'b11);
      chk("flw.pc", out_dec[0].pc, 32'h900);
      chk("flw.A_rd5", out_dec[0].A_rd[5], 1'b1);
      chk("fsw.A_rs2_5", out_dec[1].A_rs2[5], 1'b1);
      chk("fsw.alloc", out_dec[1].allocate_rd, 1'b0);

      // reset mid-operation discards entries and redirect state
      rst = 1'b0;
      tick();
      chk("midrst.out_valid", out_valid, 2'b00);
      chk("midrst.in_ready", in_ready, 1'b0);
      chk("midrst.redirect_pc", redirect_pc, 32'h0);
      rst = 1'b1;

      // fill, wrap and drain with DEPTH=8
      for (int g = 0; g < 3; g++) begin
         set_lane(0, 32'h1000 + 8 * g, I_ADDI, 0);
         set_lane(1, 32'h1004 + 8 * g, I_ADDI, 0);
         in_valid = 2'b11;
         tick();
      end
      in_valid = '0;
      #1;
      chk("fill6.in_ready", in_ready, 1'b1);
      set_lane(0, 32'h1018, I_ADDI, 0);
      set_lane(1, 32'h101C, I_ADDI, 0);
      in_valid = 2'b11;
      deq_cnt = 2'd2;
      tick();
      in_valid = '0;
      deq_cnt = '0;
      chk("wrap.pc0", out_dec[0].pc, 32'h1008);
      chk("wrap.pc1", out_dec[1].pc, 32'h100C);
      chk("wrap.in_ready", in_ready, 1'b1);
      set_lane(0, 32'h1020, I_ADDI, 0);
      in_valid = 2'b01;
      tick();
      in_valid = '0;
      chk("fill7.in_ready", in_ready, 1'b0);
      set_lane(0, 32'hDEAD0000, I_ADDI, 0);
      set_lane(1, 32'hDEAD0004, I_ADDI, 0);
      in_valid = 2'b11;
      tick();
      in_valid = '0;
      chk("fill7.hold", in_ready, 1'b0);
      deq_cnt = 2'd1;
      tick();
      deq_cnt = '0;
      chk("deq1.pc0", out_dec[0].pc, 32'h100C);
      chk("deq1.in_ready", in_ready, 1'b1);
      set_lane(0, 32'h1024, I_ADDI, 0);
      set_lane(1, 32'h1028, I_ADDI, 0);
      in_valid = 2'b11;
      tick();
      in_valid = '0;
      chk("fill8.in_ready", in_ready, 1'b0);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("drain%0d.out_valid", j), out_valid, 2'b11);
         chk($sformatf("drain%0d.pc0", j), out_dec[0].pc, 32'h100C + 8 * j);
         chk($sformatf("drain%0d.pc1", j), out_dec[1].pc, 32'h1010 + 8 * j);
         deq_cnt = 2'd2;
         tick();
      end
      deq_cnt = '0;
      chk("drain.empty", out_valid, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 2, decode/dispatch lanes per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries (power of 2, >= 2*WIDTH).
REQ-003 SHALL have parameter EARLY_JAL, default 1, enables decode-time redirect for unpredicted JAL.
REQ-004 SHALL have one clock; reset is synchronous and active-low (clk, rst).
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 in_valid  input  WIDTH  per-lane fetch valid; set lanes contiguous from lane 0.
REQ-008 in_pc / in_inst  input  WIDTH x 32 each  fetched PC and instruction per lane.
REQ-009 in_jump  input  WIDTH  fetch predicted taken.
REQ-010 in_ready  output  1  buffer can take a full WIDTH group.
REQ-011 out_valid  output  WIDTH  lane i holds the (i+1)-th oldest entry.
REQ-012 out_dec  output  WIDTH x dec_t  decoded entry: pc, inst, imm, op, f3, f7, A_rs1, A_rs2, A_rd, allocate_rd, fu_sel, jump.
REQ-013 deq_cnt  input  clog2(WIDTH+1)  entries consumed by dispatch this cycle, oldest first.
REQ-014 flush  input  1  mispredict/stall flush.
REQ-015 redirect_valid  output  1  early JAL redirect pulse.
REQ-016 redirect_pc  output  32  JAL target.

Function
REQ-017 SHALL decode each lane combinationally at enqueue and store the decoded record, not raw instruction only.
REQ-018 Decode rules SHALL be: op=inst[6:2]; FP flag bit 5 of A_rs1 for F_TYPE, A_rs2 for F_TYPE/FSTORE, A_rd for F_TYPE/FLOAD; imm per B/JAL/I/LOAD/FLOAD/JALR/S/FSTORE/LUI/AUIPC/CSR formats, else 0; fu_sel R_TYPE->{2'b0,f7[0]}, F_TYPE->3, LOAD/FLOAD->6, S_TYPE/FSTORE->7, else 0.
REQ-019 allocate_rd SHALL be 1 unless op is S_TYPE, FSTORE, B_TYPE, or A_rd==0.
REQ-020 in_ready SHALL equal (DEPTH - count >= WIDTH) && !flush && !redirect_valid.
REQ-021 Enqueue SHALL occur when in_ready && in_valid[0]; enq count = number of set in_valid lanes, written in lane order at tail.
REQ-022 With EARLY_JAL=1, the oldest enqueuing lane with op==JAL && !in_jump SHALL be enqueued with jump=1, younger lanes dropped, redirect_valid asserted next cycle for exactly one cycle, redirect_pc = that lane's pc + imm (mod 2^32).
REQ-023 out_valid[i] SHALL be (count > i); out_dec[i] = entry at head+i (mod DEPTH).
REQ-024 Dequeue SHALL remove min(deq_cnt, count) entries; deq_cnt > count SHALL be clamped, not underflow.
REQ-025 Simultaneous enqueue and dequeue SHALL update count by enq-deq in one cycle; pointers wrap modulo DEPTH.
REQ-026 Enqueued entries SHALL be visible on out_valid the cycle after enqueue (1-cycle latency).
REQ-027 flush SHALL, next cycle, set head=tail=count=0 and redirect_valid=0, ignoring same-cycle enqueue and dequeue.
REQ-028 redirect_valid coincident with flush SHALL be suppressed (flush wins).

Reset
REQ-029 While rst=0 at a clk edge: head, tail, count = 0; out_valid = 0; redirect_valid = 0; redirect_pc = 0; in_ready = 0.
REQ-030 Entry storage SHALL NOT require reset; out_dec is don't-care when out_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries and any pending redirect.

Structure
REQ-032 Opcode constants, dec_t struct, fu_sel encoding SHALL live in shared package ooo_pkg.
REQ-033 Per-lane decode SHALL be sub-module dc_decoder (combinational), instantiated WIDTH times.
REQ-034 Storage SHALL be a DEPTH-entry dec_t array with clog2(DEPTH)-bit pointers and clog2(DEPTH)+1-bit count.

Verification
REQ-035 Reset then in_valid=2'b11, pcs 0x100/0x104 ADDI -> next cycle out_valid=2'b11, imm per encoding, fu_sel=0.
REQ-036 Fill DEPTH=8 with deq_cnt=0 -> in_ready=0 at count 7 and 8; deq_cnt=2 with enqueue of 2 -> count unchanged, tail wraps to 0.
REQ-037 Lane0 JAL imm=+0x40 at pc 0x200, in_jump=0 -> only lane0 enqueued, redirect_valid 1 cycle, redirect_pc=0x240.
REQ-038 flush with count=5, concurrent enqueue of 2 and deq_cnt=1 -> next cycle count=0, out_valid=0.
REQ-039 deq_cnt=2 with count=1 -> count=0, no pointer underflow; lane1 FLW then FSW -> A_rd[5]=1 for FLW, A_rs2[5]=1 and allocate_rd=0 for FSW.
